// File: rtl/axil_pkg.sv
// rtl/axil_pkg.sv - shared AXI4-Lite types and constants for the config path
package axil_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_REQ  = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD_REQ  = 3'd3,
        ST_RD_DATA = 3'd4,
        ST_RSP     = 3'd5
    } axil_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [2:0] PROT_DEFAULT = 3'b000;

endpackage

// File: rtl/axil_cfg_master_if.sv
// rtl/axil_cfg_master_if.sv - AXI4-Lite bus bundle with master/slave views
interface axil_cfg_master_if #(
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = 32
);
    logic                          awvalid;
    logic                          awready;
    logic [AXI_ADDR_WIDTH-1:0]     awaddr;
    logic [2:0]                    awprot;
    logic                          wvalid;
    logic                          wready;
    logic [AXI_DATA_WIDTH-1:0]     wdata;
    logic [AXI_DATA_WIDTH/8-1:0]   wstrb;
    logic                          bvalid;
    logic                          bready;
    logic [1:0]                    bresp;
    logic                          arvalid;
    logic                          arready;
    logic [AXI_ADDR_WIDTH-1:0]     araddr;
    logic [2:0]                    arprot;
    logic                          rvalid;
    logic                          rready;
    logic [AXI_DATA_WIDTH-1:0]     rdata;
    logic [1:0]                    rresp;

    modport master (
        output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
        output arvalid, araddr, arprot, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
        input  arvalid, araddr, arprot, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/axil_watchdog.sv
// rtl/axil_watchdog.sv - saturating wait counter with sticky expiry flag
module axil_watchdog #(
    parameter int TIMEOUT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 enable,
    input  logic [TIMEOUT_W-1:0] limit,
    output logic                 expired
);
    logic [TIMEOUT_W-1:0] count;
    logic [TIMEOUT_W-1:0] count_inc;
    logic                 can_inc;
    logic                 hit;

    // Flag the limit on the same edge the counter reaches it; a zero limit never fires.
    always_comb begin
        count_inc = count + TIMEOUT_W'(1);
        can_inc   = enable && !clear && (count != '1);
        hit       = can_inc && (limit != '0) && (count_inc == limit);
    end

    // Counter restarts on every state entry and sticks at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (can_inc) begin
            count <= count_inc;
        end
    end

    // Expiry is sticky until reset; the transaction itself keeps waiting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            expired <= 1'b0;
        end else if (hit) begin
            expired <= 1'b1;
        end
    end
endmodule

// File: rtl/axil_cfg_master.sv
// rtl/axil_cfg_master.sv - single-outstanding AXI4-Lite master behind a cmd/rsp handshake
module axil_cfg_master
    import axil_pkg::*;
#(
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int TIMEOUT_W      = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_wr,
    input  logic [AXI_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [AXI_DATA_WIDTH-1:0] cmd_wdata,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [AXI_DATA_WIDTH-1:0] rsp_rdata,
    output logic [1:0]                rsp_resp,
    output logic                      busy,
    input  logic [TIMEOUT_W-1:0]      timeout_cycles,
    output logic                      err_timeout,
    axil_cfg_master_if.master         m_axi
);
    axil_state_e               state;
    axil_state_e               state_next;
    logic                      started;
    logic                      aw_done;
    logic                      w_done;
    logic                      aw_hs;
    logic                      w_hs;
    logic                      accept;
    logic                      wait_state;
    logic [AXI_ADDR_WIDTH-1:0] addr_q;
    logic [AXI_DATA_WIDTH-1:0] wdata_q;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and all state-decoded handshake outputs.
    always_comb begin
        state_next    = state;
        cmd_ready     = 1'b0;
        rsp_valid     = 1'b0;
        busy          = (state != ST_IDLE);
        accept        = 1'b0;
        aw_hs         = 1'b0;
        w_hs          = 1'b0;
        wait_state    = 1'b0;
        m_axi.awvalid = 1'b0;
        m_axi.wvalid  = 1'b0;
        m_axi.bready  = 1'b0;
        m_axi.arvalid = 1'b0;
        m_axi.rready  = 1'b0;
        m_axi.awaddr  = addr_q & ~AXI_ADDR_WIDTH'(3);
        m_axi.araddr  = addr_q & ~AXI_ADDR_WIDTH'(3);
        m_axi.awprot  = PROT_DEFAULT;
        m_axi.arprot  = PROT_DEFAULT;
        m_axi.wdata   = wdata_q;
        m_axi.wstrb   = '1;
        case (state)
            ST_IDLE: begin
                cmd_ready = started;
                accept    = started && cmd_valid;
                if (accept) begin
                    state_next = cmd_wr ? ST_WR_REQ : ST_RD_REQ;
                end
            end
            ST_WR_REQ: begin
                wait_state    = 1'b1;
                m_axi.awvalid = !aw_done;
                m_axi.wvalid  = !w_done;
                aw_hs         = !aw_done && m_axi.awready;
                w_hs          = !w_done && m_axi.wready;
                if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                    state_next = ST_WR_RESP;
                end
            end
            ST_WR_RESP: begin
                wait_state   = 1'b1;
                m_axi.bready = 1'b1;
                if (m_axi.bvalid) begin
                    state_next = ST_RSP;
                end
            end
            ST_RD_REQ: begin
                wait_state    = 1'b1;
                m_axi.arvalid = 1'b1;
                if (m_axi.arready) begin
                    state_next = ST_RD_DATA;
                end
            end
            ST_RD_DATA: begin
                wait_state   = 1'b1;
                m_axi.rready = 1'b1;
                if (m_axi.rvalid) begin
                    state_next = ST_RSP;
                end
            end
            ST_RSP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Command capture, per-channel write completion and response capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            started   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            rsp_rdata <= '0;
            rsp_resp  <= RESP_OKAY;
        end else begin
            started <= 1'b1;
            if (accept) begin
                addr_q  <= cmd_addr;
                wdata_q <= cmd_wdata;
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end else begin
                if (aw_hs) aw_done <= 1'b1;
                if (w_hs)  w_done  <= 1'b1;
            end
            if (state == ST_WR_RESP && m_axi.bvalid) begin
                rsp_rdata <= '0;
                rsp_resp  <= m_axi.bresp;
            end
            if (state == ST_RD_DATA && m_axi.rvalid) begin
                rsp_rdata <= m_axi.rdata;
                rsp_resp  <= m_axi.rresp;
            end
        end
    end

    axil_watchdog #(
        .TIMEOUT_W (TIMEOUT_W)
    ) u_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (state_next != state),
        .enable  (wait_state),
        .limit   (timeout_cycles),
        .expired (err_timeout)
    );
endmodule
